// File: rtl/tx_frame_sequencer_pkg.sv
// Symbol constants, sequencer state encoding and length helper shared by RTL and bench.
package tx_frame_sequencer_pkg;

  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_IDL = 8'h7C;
  localparam logic [7:0] SYM_FTS = 8'h3C;
  localparam logic [7:0] SYM_COM = 8'hBC;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SKP_OS,
    ST_START,
    ST_PAYLOAD,
    ST_FRAME_END
  } tx_state_e;

  // A 4-bit TLP length of zero encodes the maximum of 16 bytes.
  function automatic logic [4:0] tlp_len_decode(input logic [3:0] len);
    return (len == 4'd0) ? 5'd16 : {1'b0, len};
  endfunction

endpackage

// File: rtl/tx_rr_arb.sv
// Two-way round-robin pick between TLP and DLLP; combinational pick, registered last-grant bit.
// Latency 0 for the pick; last-grant updates on the edge where i_update is high. No backpressure.
module tx_rr_arb
  import tx_frame_sequencer_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_tlp,
  input  logic i_req_dllp,
  input  logic i_update,
  output logic o_any,
  output logic o_pick_dllp
);

  logic r_last_dllp;
  logic w_pick_dllp;

  // DLLP wins when it is alone, or on a tie when TLP was granted last.
  assign w_pick_dllp = i_req_dllp & (~i_req_tlp | ~r_last_dllp);
  assign o_pick_dllp = w_pick_dllp;
  assign o_any       = i_req_tlp | i_req_dllp;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_dllp <= 1'b0;
    end else if (i_update) begin
      r_last_dllp <= w_pick_dllp;
    end
  end

endmodule

// File: rtl/tx_frame_sequencer.sv
// Transmit symbol scheduler: frames TLP/DLLP packets, fills with IDL, inserts SKP sets at frame boundaries.
// One symbol per clock, all outputs registered; requesters are paced by gnt/rd, output is never stalled.
module tx_frame_sequencer
  import tx_frame_sequencer_pkg::*;
#(
  parameter int SKP_INTERVAL = 64,
  parameter int DLLP_LEN     = 2
) (
  input  logic       clk_1m,
  input  logic       reset_L,
  input  logic       tlp_req,
  input  logic [3:0] tlp_len,
  input  logic [7:0] tlp_data,
  output logic       tlp_gnt,
  output logic       tlp_rd,
  input  logic       dllp_req,
  input  logic [7:0] dllp_data,
  output logic       dllp_gnt,
  output logic       dllp_rd,
  output logic [7:0] data_out,
  output logic       k_out,
  output logic       valid_out
);

  localparam logic [7:0] SKP_MAX    = 8'(SKP_INTERVAL);
  localparam logic [4:0] DLLP_LEN_W = 5'(DLLP_LEN);

  tx_state_e r_state;
  tx_state_e w_nxt_state;
  logic [4:0] r_idx;
  logic [4:0] w_nxt_idx;
  logic [4:0] r_len;
  logic [4:0] w_nxt_len;
  logic [4:0] w_len_last;
  logic       r_sel_dllp;
  logic [7:0] r_skp_cnt;
  logic       w_skp_pending;
  logic       w_skp_clear;
  logic       w_boundary;
  logic       w_arb_update;
  logic       w_any_req;
  logic       w_pick_dllp;

  logic [7:0] r_data;
  logic       r_k;
  logic       r_valid;
  logic       r_tlp_gnt;
  logic       r_dllp_gnt;
  logic       r_tlp_rd;
  logic       r_dllp_rd;
  logic [7:0] w_nxt_data;
  logic       w_nxt_k;
  logic       w_nxt_tlp_gnt;
  logic       w_nxt_dllp_gnt;
  logic       w_nxt_tlp_rd;
  logic       w_nxt_dllp_rd;

  tx_rr_arb u_arb (
    .i_clk       (clk_1m),
    .i_rst_n     (reset_L),
    .i_req_tlp   (tlp_req),
    .i_req_dllp  (dllp_req),
    .i_update    (w_arb_update),
    .o_any       (w_any_req),
    .o_pick_dllp (w_pick_dllp)
  );

  assign w_skp_pending = (r_skp_cnt == SKP_MAX);
  assign w_len_last    = r_len - 5'd1;
  assign w_nxt_len     = w_pick_dllp ? DLLP_LEN_W : tlp_len_decode(tlp_len);
  assign w_skp_clear   = (w_nxt_state == ST_SKP_OS) && (w_nxt_idx == 5'd0);

  // r_state/r_idx describe the symbol currently on data_out; INIT with valid low means nothing sent yet.
  assign w_boundary = (r_state == ST_IDLE) || (r_state == ST_FRAME_END) ||
                      (((r_state == ST_SKP_OS) || ((r_state == ST_INIT) && r_valid)) &&
                       (r_idx == 5'd3));

  always_ff @(posedge clk_1m or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= ST_INIT;
      r_idx      <= 5'd0;
      r_len      <= 5'd0;
      r_sel_dllp <= 1'b0;
      r_skp_cnt  <= 8'd0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      if (w_arb_update) begin
        r_len      <= w_nxt_len;
        r_sel_dllp <= w_pick_dllp;
      end
      if (w_skp_clear) begin
        r_skp_cnt <= 8'd0;
      end else if (!w_skp_pending) begin
        r_skp_cnt <= r_skp_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_idx    = r_idx;
    w_arb_update = 1'b0;
    if (w_boundary) begin
      w_nxt_idx = 5'd0;
      if (w_skp_pending) begin
        w_nxt_state = ST_SKP_OS;
      end else if (w_any_req) begin
        w_nxt_state  = ST_START;
        w_arb_update = 1'b1;
      end else begin
        w_nxt_state = ST_IDLE;
      end
    end else begin
      case (r_state)
        ST_INIT: begin
          w_nxt_idx = r_valid ? (r_idx + 5'd1) : 5'd0;
        end
        ST_SKP_OS: begin
          w_nxt_idx = r_idx + 5'd1;
        end
        ST_START: begin
          w_nxt_state = ST_PAYLOAD;
          w_nxt_idx   = 5'd0;
        end
        ST_PAYLOAD: begin
          if (r_idx == w_len_last) begin
            w_nxt_state = ST_FRAME_END;
            w_nxt_idx   = 5'd0;
          end else begin
            w_nxt_idx = r_idx + 5'd1;
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_idx   = 5'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so the symbol appears on the edge that enters a state.
  always_comb begin
    w_nxt_data     = SYM_IDL;
    w_nxt_k        = 1'b1;
    w_nxt_tlp_gnt  = 1'b0;
    w_nxt_dllp_gnt = 1'b0;
    w_nxt_tlp_rd   = 1'b0;
    w_nxt_dllp_rd  = 1'b0;
    case (w_nxt_state)
      ST_INIT:   w_nxt_data = SYM_COM;
      ST_IDLE:   w_nxt_data = SYM_IDL;
      ST_SKP_OS: w_nxt_data = (w_nxt_idx == 5'd0) ? SYM_COM : SYM_SKP;
      ST_START: begin
        w_nxt_data     = w_pick_dllp ? SYM_SDP : SYM_STP;
        w_nxt_tlp_gnt  = ~w_pick_dllp;
        w_nxt_dllp_gnt = w_pick_dllp;
        w_nxt_tlp_rd   = ~w_pick_dllp;
        w_nxt_dllp_rd  = w_pick_dllp;
      end
      ST_PAYLOAD: begin
        w_nxt_data    = r_sel_dllp ? dllp_data : tlp_data;
        w_nxt_k       = 1'b0;
        w_nxt_tlp_rd  = ~r_sel_dllp & (w_nxt_idx != w_len_last);
        w_nxt_dllp_rd = r_sel_dllp & (w_nxt_idx != w_len_last);
      end
      ST_FRAME_END: w_nxt_data = SYM_END;
      default:      w_nxt_data = SYM_IDL;
    endcase
  end

  always_ff @(posedge clk_1m or negedge reset_L) begin
    if (!reset_L) begin
      r_data     <= 8'h00;
      r_k        <= 1'b0;
      r_valid    <= 1'b0;
      r_tlp_gnt  <= 1'b0;
      r_dllp_gnt <= 1'b0;
      r_tlp_rd   <= 1'b0;
      r_dllp_rd  <= 1'b0;
    end else begin
      r_data     <= w_nxt_data;
      r_k        <= w_nxt_k;
      r_valid    <= 1'b1;
      r_tlp_gnt  <= w_nxt_tlp_gnt;
      r_dllp_gnt <= w_nxt_dllp_gnt;
      r_tlp_rd   <= w_nxt_tlp_rd;
      r_dllp_rd  <= w_nxt_dllp_rd;
    end
  end

  assign data_out  = r_data;
  assign k_out     = r_k;
  assign valid_out = r_valid;
  assign tlp_gnt   = r_tlp_gnt;
  assign dllp_gnt  = r_dllp_gnt;
  assign tlp_rd    = r_tlp_rd;
  assign dllp_rd   = r_dllp_rd;

endmodule

// File: doc/tx_frame_sequencer.md
# tx_frame_sequencer

Transmit-side scheduler that owns the single byte stream feeding the lane demux. It shares that stream between a TLP requester and a DLLP requester, frames each packet (STP…END, SDP…END), fills the gaps with IDL, and forces a SKP ordered set (COM + 3×SKP) at frame boundaries on a fixed interval. After reset it emits one COM ordered set (4×COM) before going idle. One symbol per clock, registered outputs.

## Interface
- SKP_INTERVAL, 64: symbols between SKP ordered sets; range 8..255.
- DLLP_LEN, 2: DLLP payload bytes per frame; range 1..8.
- clk_1m  in  1  symbol clock.
- reset_L  in  1  asynchronous, active-low reset.
- tlp_req  in  1  TLP pending; held high until the grant.
- tlp_len  in  4  TLP payload bytes; 0 means 16; stable while tlp_req=1.
- tlp_data  in  8  current TLP byte (show-ahead).
- tlp_gnt  out  1  one-cycle pulse, coincident with STP on data_out.
- tlp_rd  out  1  tlp_data consumed at the end of this cycle.
- dllp_req, dllp_data, dllp_gnt, dllp_rd: same meaning for DLLP (8-bit data), start symbol SDP.
- data_out  out  8  symbol.
- k_out  out  1  1 = control symbol, 0 = payload byte.
- valid_out  out  1  symbol valid.

## Operation
- Symbols in the shared package: STP=FB, SDP=5C, END=FD, EDB=FE, SKP=1C, IDL=7C, FTS=3C, COM=BC. EDB and FTS are never emitted.
- States: INIT, IDLE, SKP_OS, START, PAYLOAD, FRAME_END.
- INIT: emits COM four times (k=1), then goes to IDLE.
- IDLE: emits IDL (k=1) every cycle.
- Boundary edge: any edge whose next symbol would be IDL, plus the edge after END and the edge after the 3rd SKP. At a boundary the priority is:
  - skp_pending → SKP_OS.
  - Both requests high → round-robin winner; the last_grant bit flips on every grant and resets to "TLP last", so DLLP wins the first tie.
  - Single request → that requester.
  - Otherwise → IDLE.
- SKP_OS: emits COM, SKP, SKP, SKP, then the next boundary. Never entered mid-frame.
- START: emits STP or SDP and pulses the matching gnt. The length is latched here (DLLP_LEN, or tlp_len with 0 mapped to 16).
- PAYLOAD: emits the latched length of bytes (k=0), data_out = sampled requester data. The rd output is high in the cycle before each byte appears.
- FRAME_END: emits END, then the next boundary. Back-to-back frames and a frame directly after SKP_OS are allowed.
- SKP counter:
  - Increments on every valid symbol and saturates at SKP_INTERVAL.
  - skp_pending = (count == SKP_INTERVAL).
  - Cleared to 0 on the edge that emits COM of SKP_OS.
  - Not cleared by the INIT COMs.
- req deasserted after its gnt is ignored until FRAME_END. The requester must supply exactly len bytes.

## Timing
- Reset values:
  - data_out=00, k_out=0, valid_out=0.
  - tlp_gnt, dllp_gnt, tlp_rd, dllp_rd = 0.
  - state=INIT, SKP counter=0, last_grant=TLP.
- First edge with reset_L=1 emits the first COM with valid_out=1. valid_out stays 1 until reset.
- Request to start symbol: req sampled high at boundary edge k → STP/SDP on data_out after edge k (1 cycle).
- rd timing: tlp_rd=1 in the STP cycle and in every payload cycle except the last. Payload byte i appears one cycle after rd pulse i.
- Frame length on the wire: len+2 symbols.
- Reset asserted mid-frame or mid-SKP_OS: outputs go to reset values immediately (async). No END or EDB is emitted. The requester must re-request after reset.

## Structure
- Shared package (e.g. pcie_sym_pkg): the 8 symbol constants and the state enum. The test bench's symbol decoder imports the same package.
- One sub-module, tx_rr_arb: a 2-way round-robin arbiter with a registered last_grant bit and an update strobe.
- Sequencer target: ~200 lines.

## Test plan
- Reset release, no requests → COM×4, then IDL continuously with k=1. SKP_OS (BC,1C,1C,1C) starts exactly when the counter reaches SKP_INTERVAL.
- tlp_req with tlp_len=2, data 01,02 → FB,01,02,FD with k=1,0,0,1. tlp_gnt coincides with FB. tlp_rd high for 2 cycles starting at FB.
- tlp_req and dllp_req held together, DLLP_LEN=2 → SDP frame first, then STP frame, then SDP again, with no IDL between frames.
- tlp_len=0 with data 03..12 → STP, 16 payload bytes, END; 18 symbols total.
- skp_pending goes high during a 16-byte TLP → SKP_OS immediately follows END, never inside the frame, and the counter restarts at COM.
- reset_L pulsed low during PAYLOAD → outputs are 0 that cycle with no END. After release: COM×4, then a fresh grant.
